axis_adapter_arbiter: RTL and testbench
=======================================

Name: axis_adapter_arbiter

Overview:
- Shares one AXIS-to-AXI adapter between NUM_PORTS requesters, e.g. framebuffer writeback, depth/stencil and texture fetch.
- Each requester submits a command (start address, length in beats) plus a stream.
- The arbiter grants one requester at a time, round-robin. It forwards that requester's command to the adapter and routes both stream directions to and from it.
- The grant is released when the adapter pulses command completion.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8)
- DATA_WIDTH, 32, stream data width
- ADDR_WIDTH, 32, address and beat-count width
- STRB_WIDTH, 4, strobe width (DATA_WIDTH/8)
- AXI_LAST_MASK, 0, bit i set: port i transfers use AXI-burst last semantics (adapter enableAxiLastSignal=1)

Ports:
- aclk  in  1  clock
- resetn  in  1  reset
- req_valid  in  NUM_PORTS  command request per port
- req_addr  in  NUM_PORTS*ADDR_WIDTH  start address, port i at slice i
- req_beats  in  NUM_PORTS*ADDR_WIDTH  transfer length in beats
- req_ready  out  NUM_PORTS  one-cycle completion pulse per port
- wr_data  in  NUM_PORTS*DATA_WIDTH  requester write stream data
- wr_strb  in  NUM_PORTS*STRB_WIDTH  write strobes
- wr_last  in  NUM_PORTS  write last
- wr_valid  in  NUM_PORTS  write valid
- wr_ready  out  NUM_PORTS  write ready
- rd_data  out  DATA_WIDTH  read stream data, broadcast to all ports
- rd_strb  out  STRB_WIDTH  read strobes, broadcast
- rd_last  out  1  read last, broadcast
- rd_valid  out  NUM_PORTS  read valid, granted port only
- rd_ready  in  NUM_PORTS  read ready
- ad_avalid  out  1  adapter command valid
- ad_aaddr  out  ADDR_WIDTH  adapter start address
- ad_abeats  out  ADDR_WIDTH  adapter beat count
- ad_aready  in  1  adapter completion pulse
- ad_enableAxiLast  out  1  adapter last-signal mode
- ad_sxdata, ad_sxstrb, ad_sxlast, ad_sxvalid  out  DATA_WIDTH, STRB_WIDTH, 1, 1  stream into adapter
- ad_sxready  in  1  adapter input ready
- ad_mxdata, ad_mxstrb, ad_mxlast, ad_mxvalid  in  DATA_WIDTH, STRB_WIDTH, 1, 1  stream out of adapter
- ad_mxready  out  1  adapter output ready
- grant  out  NUM_PORTS  one-hot current owner; 0 when none
- busy  out  1  a transfer is in flight

Behaviour:
- Clock and reset: one clock, aclk. resetn is asynchronous, active-low. Reset is applied to the arbiter and the adapter together.
- Reset values:
  - State IDLE; grant=0; busy=0; ad_avalid=0; req_ready=0.
  - Round-robin pointer = 0, so port 0 has highest priority first.
  - ad_aaddr, ad_abeats and ad_enableAxiLast reset to 0.
  - Combinational outputs are gated by grant, so wr_ready, rd_valid, ad_sxvalid and ad_mxready are 0 in reset.
- State machine: IDLE -> GRANT -> DONE -> IDLE. All state, grant and command registers are clocked.
- IDLE:
  - Choose the first port with req_valid set, searching from the pointer upward and wrapping modulo NUM_PORTS.
  - On the next edge: register grant (one-hot), ad_aaddr/ad_abeats from that port's slice, and ad_enableAxiLast=AXI_LAST_MASK[i]; set ad_avalid=1, busy=1; go to GRANT.
  - Latency: req_valid seen in cycle N gives ad_avalid=1 in cycle N+1.
- Zero-length command (req_beats==0): the command is never issued to the adapter.
  - IDLE goes directly to DONE, with ad_avalid=0 and grant=0.
  - req_ready[i] pulses in cycle N+1.
- GRANT:
  - Hold ad_avalid=1 and the command stable until ad_aready==1.
  - On the edge after ad_aready: ad_avalid=0, grant=0, req_ready[i]=1 for one cycle, pointer=(i+1) mod NUM_PORTS, go to DONE.
  - ad_avalid must be low in the cycle after ad_aready. The adapter re-arms one cycle after its completion pulse.
  - ad_aready seen while not in GRANT is ignored.
- DONE: lasts one cycle, no arbitration, busy=0, then IDLE. A requester may keep req_valid high during the req_ready cycle without being re-granted. Earliest next grant is 2 cycles after completion.
- Write routing, combinational from the registered grant:
  - ad_sx* come from the granted port's wr_* slice.
  - wr_ready[i] = grant[i] & ad_sxready.
  - Ungranted ports see wr_ready=0. With no grant, ad_sxvalid=0.
- Read routing:
  - rd_valid[i] = grant[i] & ad_mxvalid.
  - ad_mxready = OR over i of (grant[i] & rd_ready[i]).
  - rd_data, rd_strb and rd_last pass ad_mx* straight through.
- Requester-side rules:
  - req_addr and req_beats must stay stable while req_valid is high. They are sampled only in IDLE.
  - Dropping req_valid before the grant withdraws the request. No event results.
- Reset mid-transfer: all outputs return to reset values asynchronously. The in-flight transfer is abandoned and no req_ready is issued.
- Simultaneous requests: exactly one grant per arbitration. Pointer order guarantees every requesting port is served within NUM_PORTS transfers.

Test Plan:
- Single request: port 2 req_addr=0x1000, req_beats=32 in cycle 5 -> ad_avalid=1 with ad_aaddr=0x1000, ad_abeats=32, grant=4'b0100 in cycle 6. Adapter ad_aready in cycle 40 -> req_ready[2] in cycle 41, ad_avalid=0 in cycle 41, busy=0.
- All four ports request at once and hold req_valid -> grant order 0,1,2,3,0. Each completion is followed by a 2-cycle gap to the next ad_avalid.
- Write routing: port 1 granted, ports 0 and 3 drive wr_valid -> only wr_ready[1] follows ad_sxready; ad_sxdata equals the port 1 slice for all 16 beats.
- Read backpressure: port 3 granted, rd_ready[3] toggles 1,0,0,1 -> ad_mxready mirrors it; rd_valid[0..2] stay 0.
- Zero-length: port 0 req_beats=0 -> ad_avalid never asserts; req_ready[0] pulses 1 cycle after the request; the pointer advances to 1.
- Reset: resetn low mid-GRANT, asynchronously between clock edges -> grant=0, ad_avalid=0, busy=0 without waiting for an edge. After release, port 0 wins when ports 0 and 2 both request.

Source files
------------

// File: rtl/axis_adapter_arbiter.sv
// Round-robin arbiter that lends a single AXIS-to-AXI adapter to one requester at a time.
// Each grant carries one command and its stream traffic, and lasts until the adapter reports completion.
module axis_adapter_arbiter #(
    parameter int                   NUM_PORTS     = 4,
    parameter int                   DATA_WIDTH    = 32,
    parameter int                   ADDR_WIDTH    = 32,
    parameter int                   STRB_WIDTH    = 4,
    parameter logic [NUM_PORTS-1:0] AXI_LAST_MASK = '0
) (
    input  logic                             aclk,
    input  logic                             resetn,
    input  logic [NUM_PORTS-1:0]             req_valid,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_beats,
    output logic [NUM_PORTS-1:0]             req_ready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wr_data,
    input  logic [NUM_PORTS*STRB_WIDTH-1:0]  wr_strb,
    input  logic [NUM_PORTS-1:0]             wr_last,
    input  logic [NUM_PORTS-1:0]             wr_valid,
    output logic [NUM_PORTS-1:0]             wr_ready,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic [STRB_WIDTH-1:0]            rd_strb,
    output logic                             rd_last,
    output logic [NUM_PORTS-1:0]             rd_valid,
    input  logic [NUM_PORTS-1:0]             rd_ready,
    output logic                             ad_avalid,
    output logic [ADDR_WIDTH-1:0]            ad_aaddr,
    output logic [ADDR_WIDTH-1:0]            ad_abeats,
    input  logic                             ad_aready,
    output logic                             ad_enableAxiLast,
    output logic [DATA_WIDTH-1:0]            ad_sxdata,
    output logic [STRB_WIDTH-1:0]            ad_sxstrb,
    output logic                             ad_sxlast,
    output logic                             ad_sxvalid,
    input  logic                             ad_sxready,
    input  logic [DATA_WIDTH-1:0]            ad_mxdata,
    input  logic [STRB_WIDTH-1:0]            ad_mxstrb,
    input  logic                             ad_mxlast,
    input  logic                             ad_mxvalid,
    output logic                             ad_mxready,
    output logic [NUM_PORTS-1:0]             grant,
    output logic                             busy
);

    localparam int PTR_W = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [NUM_PORTS-1:0]   req_ready_q, req_ready_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       cur_q, cur_d;
    logic [ADDR_WIDTH-1:0]  aaddr_q, aaddr_d;
    logic [ADDR_WIDTH-1:0]  abeats_q, abeats_d;
    logic                   axilast_q, axilast_d;
    logic                   found;
    logic [PTR_W-1:0]       sel;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_PORTS) s = s - NUM_PORTS;
        return PTR_W'(s);
    endfunction

    // First requesting port at or after the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!found && req_valid[wrap_add(ptr_q, k)]) begin
                found = 1'b1;
                sel   = wrap_add(ptr_q, k);
            end
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            req_ready_q <= '0;
            ptr_q       <= '0;
            cur_q       <= '0;
            aaddr_q     <= '0;
            abeats_q    <= '0;
            axilast_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            req_ready_q <= req_ready_d;
            ptr_q       <= ptr_d;
            cur_q       <= cur_d;
            aaddr_q     <= aaddr_d;
            abeats_q    <= abeats_d;
            axilast_q   <= axilast_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        req_ready_d = '0;
        ptr_d       = ptr_q;
        cur_d       = cur_q;
        aaddr_d     = aaddr_q;
        abeats_d    = abeats_q;
        axilast_d   = axilast_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    // A zero-beat command completes immediately without ever reaching the adapter.
                    if (req_beats[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH] == '0) begin
                        state_d          = DONE;
                        req_ready_d[sel] = 1'b1;
                        ptr_d            = wrap_add(sel, 1);
                    end else begin
                        state_d   = GRANT;
                        grant_d   = NUM_PORTS'(1) << sel;
                        cur_d     = sel;
                        aaddr_d   = req_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
                        abeats_d  = req_beats[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
                        axilast_d = AXI_LAST_MASK[sel];
                    end
                end
            end
            GRANT: begin
                if (ad_aready) begin
                    state_d            = DONE;
                    grant_d            = '0;
                    req_ready_d[cur_q] = 1'b1;
                    ptr_d              = wrap_add(cur_q, 1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign grant            = grant_q;
    assign busy             = (state_q == GRANT);
    assign ad_avalid        = (state_q == GRANT);
    assign req_ready        = req_ready_q;
    assign ad_aaddr         = aaddr_q;
    assign ad_abeats        = abeats_q;
    assign ad_enableAxiLast = axilast_q;

    // Write stream mux; with no grant every field stays zero.
    always_comb begin
        ad_sxdata  = '0;
        ad_sxstrb  = '0;
        ad_sxlast  = 1'b0;
        ad_sxvalid = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q[i]) begin
                ad_sxdata  = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                ad_sxstrb  = wr_strb[i*STRB_WIDTH +: STRB_WIDTH];
                ad_sxlast  = wr_last[i];
                ad_sxvalid = wr_valid[i];
            end
        end
    end

    assign wr_ready   = grant_q & {NUM_PORTS{ad_sxready}};
    assign rd_valid   = grant_q & {NUM_PORTS{ad_mxvalid}};
    assign ad_mxready = |(grant_q & rd_ready);
    assign rd_data    = ad_mxdata;
    assign rd_strb    = ad_mxstrb;
    assign rd_last    = ad_mxlast;

endmodule

// File: tb/tb_axis_adapter_arbiter.sv
// Directed bench for axis_adapter_arbiter: reset state, arbitration order, stream routing,
// zero-length commands and asynchronous reset in the middle of a transfer.
module tb_axis_adapter_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;

    logic              aclk;
    logic              resetn;
    logic [NP-1:0]     req_valid;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*AW-1:0]  req_beats;
    logic [NP-1:0]     req_ready;
    logic [NP*DW-1:0]  wr_data;
    logic [NP*SW-1:0]  wr_strb;
    logic [NP-1:0]     wr_last;
    logic [NP-1:0]     wr_valid;
    logic [NP-1:0]     wr_ready;
    logic [DW-1:0]     rd_data;
    logic [SW-1:0]     rd_strb;
    logic              rd_last;
    logic [NP-1:0]     rd_valid;
    logic [NP-1:0]     rd_ready;
    logic              ad_avalid;
    logic [AW-1:0]     ad_aaddr;
    logic [AW-1:0]     ad_abeats;
    logic              ad_aready;
    logic              ad_enableAxiLast;
    logic [DW-1:0]     ad_sxdata;
    logic [SW-1:0]     ad_sxstrb;
    logic              ad_sxlast;
    logic              ad_sxvalid;
    logic              ad_sxready;
    logic [DW-1:0]     ad_mxdata;
    logic [SW-1:0]     ad_mxstrb;
    logic              ad_mxlast;
    logic              ad_mxvalid;
    logic              ad_mxready;
    logic [NP-1:0]     grant;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    axis_adapter_arbiter #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW),
        .AXI_LAST_MASK(4'b1000)
    ) dut (
        .aclk(aclk), .resetn(resetn),
        .req_valid(req_valid), .req_addr(req_addr), .req_beats(req_beats), .req_ready(req_ready),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_last(wr_last), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_strb(rd_strb), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .ad_avalid(ad_avalid), .ad_aaddr(ad_aaddr), .ad_abeats(ad_abeats), .ad_aready(ad_aready),
        .ad_enableAxiLast(ad_enableAxiLast),
        .ad_sxdata(ad_sxdata), .ad_sxstrb(ad_sxstrb), .ad_sxlast(ad_sxlast), .ad_sxvalid(ad_sxvalid),
        .ad_sxready(ad_sxready),
        .ad_mxdata(ad_mxdata), .ad_mxstrb(ad_mxstrb), .ad_mxlast(ad_mxlast), .ad_mxvalid(ad_mxvalid),
        .ad_mxready(ad_mxready),
        .grant(grant), .busy(busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic apply_stimulus_clear();
        req_valid  = '0;
        req_addr   = '0;
        req_beats  = '0;
        wr_data    = '0;
        wr_strb    = '0;
        wr_last    = '0;
        wr_valid   = '0;
        rd_ready   = '0;
        ad_aready  = 1'b0;
        ad_sxready = 1'b0;
        ad_mxdata  = '0;
        ad_mxstrb  = '0;
        ad_mxlast  = 1'b0;
        ad_mxvalid = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        apply_stimulus_clear();
        step();
        step();
        resetn = 1'b1;
        step();
    endtask

    // Single-cycle completion pulse from the adapter model.
    task automatic complete();
        ad_aready = 1'b1;
        step();
        ad_aready = 1'b0;
    endtask

    initial begin
        logic [3:0] seq;
        logic       sx;
        int         exp_port;

        resetn = 1'b0;
        apply_stimulus_clear();
        wr_valid   = 4'hF;
        ad_sxready = 1'b1;
        rd_ready   = 4'hF;
        ad_mxvalid = 1'b1;
        step();
        step();
        check_output("rst_grant", 64'(grant), 64'h0);
        check_output("rst_busy", 64'(busy), 64'h0);
        check_output("rst_avalid", 64'(ad_avalid), 64'h0);
        check_output("rst_req_ready", 64'(req_ready), 64'h0);
        check_output("rst_aaddr", 64'(ad_aaddr), 64'h0);
        check_output("rst_wr_ready", 64'(wr_ready), 64'h0);
        check_output("rst_sxvalid", 64'(ad_sxvalid), 64'h0);
        check_output("rst_mxready", 64'(ad_mxready), 64'h0);
        check_output("rst_rd_valid", 64'(rd_valid), 64'h0);
        do_reset();

        $display("[TB] single request on port 2");
        req_valid[2]        = 1'b1;
        req_addr[2*AW +: AW]  = 32'h1000;
        req_beats[2*AW +: AW] = 32'd32;
        step();
        check_output("single_avalid", 64'(ad_avalid), 64'h1);
        check_output("single_aaddr", 64'(ad_aaddr), 64'h1000);
        check_output("single_abeats", 64'(ad_abeats), 64'd32);
        check_output("single_grant", 64'(grant), 64'h4);
        check_output("single_busy", 64'(busy), 64'h1);
        check_output("single_axilast", 64'(ad_enableAxiLast), 64'h0);
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("single_hold_avalid", 64'(ad_avalid), 64'h1);
            check_output("single_hold_req_ready", 64'(req_ready), 64'h0);
        end
        complete();
        check_output("single_req_ready", 64'(req_ready), 64'h4);
        check_output("single_avalid_drop", 64'(ad_avalid), 64'h0);
        check_output("single_busy_drop", 64'(busy), 64'h0);
        check_output("single_grant_drop", 64'(grant), 64'h0);
        step();
        check_output("single_req_ready_pulse", 64'(req_ready), 64'h0);

        $display("[TB] four simultaneous requesters");
        do_reset();
        for (int i = 0; i < NP; i++) begin
            req_addr[i*AW +: AW]  = 32'h4000 + 32'(i) * 32'h100;
            req_beats[i*AW +: AW] = 32'(i + 1);
        end
        req_valid = 4'hF;
        step();
        for (int k = 0; k < 5; k++) begin
            exp_port = k % NP;
            check_output("rr_grant", 64'(grant), 64'h1 << exp_port);
            check_output("rr_aaddr", 64'(ad_aaddr), 64'h4000 + 64'(exp_port) * 64'h100);
            check_output("rr_abeats", 64'(ad_abeats), 64'(exp_port + 1));
            check_output("rr_axilast", 64'(ad_enableAxiLast), (exp_port == 3) ? 64'h1 : 64'h0);
            step();
            complete();
            check_output("rr_req_ready", 64'(req_ready), 64'h1 << exp_port);
            check_output("rr_avalid_done", 64'(ad_avalid), 64'h0);
            if (k == 4) req_valid = '0;
            step();
            check_output("rr_gap_avalid", 64'(ad_avalid), 64'h0);
            check_output("rr_gap_req_ready", 64'(req_ready), 64'h0);
            step();
            check_output("rr_next_avalid", 64'(ad_avalid), (k < 4) ? 64'h1 : 64'h0);
        end

        $display("[TB] write routing through port 1");
        req_valid = 4'b0010;
        req_addr[1*AW +: AW]  = 32'h2000;
        req_beats[1*AW +: AW] = 32'd16;
        step();
        req_valid = '0;
        check_output("wr_grant", 64'(grant), 64'h2);
        for (int b = 0; b < 16; b++) begin
            sx = (b % 3) != 0;
            wr_valid             = 4'b1011;
            wr_data[0*DW +: DW]  = 32'hAAAA0000 + 32'(b);
            wr_data[1*DW +: DW]  = 32'h11110000 + 32'(b);
            wr_data[3*DW +: DW]  = 32'h33330000 + 32'(b);
            wr_strb              = {4'hF, 4'h0, 4'(b), 4'hF};
            wr_last              = {1'b1, 1'b0, (b == 15), 1'b1};
            ad_sxready           = sx;
            #1;
            check_output("wr_ready", 64'(wr_ready), sx ? 64'h2 : 64'h0);
            check_output("wr_sxdata", 64'(ad_sxdata), 64'h11110000 + 64'(b));
            check_output("wr_sxstrb", 64'(ad_sxstrb), 64'(b % 16));
            check_output("wr_sxlast", 64'(ad_sxlast), (b == 15) ? 64'h1 : 64'h0);
            check_output("wr_sxvalid", 64'(ad_sxvalid), 64'h1);
            step();
        end
        wr_valid   = '0;
        ad_sxready = 1'b0;
        complete();
        check_output("wr_req_ready", 64'(req_ready), 64'h2);
        step();

        $display("[TB] read backpressure on port 3");
        req_valid = 4'b1000;
        req_addr[3*AW +: AW]  = 32'h3000;
        req_beats[3*AW +: AW] = 32'd4;
        step();
        req_valid = '0;
        check_output("rd_grant", 64'(grant), 64'h8);
        check_output("rd_axilast", 64'(ad_enableAxiLast), 64'h1);
        seq = 4'b1001;
        for (int j = 0; j < 4; j++) begin
            ad_mxvalid = 1'b1;
            ad_mxdata  = 32'hCAFE0000 + 32'(j);
            ad_mxstrb  = 4'(j + 5);
            rd_ready   = {seq[3-j], 3'b111};
            #1;
            check_output("rd_mxready", 64'(ad_mxready), 64'(seq[3-j]));
            check_output("rd_valid", 64'(rd_valid), 64'h8);
            check_output("rd_data", 64'(rd_data), 64'hCAFE0000 + 64'(j));
            check_output("rd_strb", 64'(rd_strb), 64'(j + 5));
            step();
        end
        ad_mxvalid = 1'b0;
        rd_ready   = '0;
        #1;
        check_output("rd_valid_idle", 64'(rd_valid), 64'h0);
        complete();
        check_output("rd_req_ready", 64'(req_ready), 64'h8);
        step();

        $display("[TB] zero-length command on port 0");
        req_valid = 4'b0001;
        req_addr[0*AW +: AW]  = 32'h5000;
        req_beats[0*AW +: AW] = 32'd0;
        step();
        check_output("zl_req_ready", 64'(req_ready), 64'h1);
        check_output("zl_avalid", 64'(ad_avalid), 64'h0);
        check_output("zl_grant", 64'(grant), 64'h0);
        check_output("zl_busy", 64'(busy), 64'h0);
        req_valid = '0;
        step();
        check_output("zl_req_ready_pulse", 64'(req_ready), 64'h0);
        check_output("zl_avalid_after", 64'(ad_avalid), 64'h0);
        req_beats[0*AW +: AW] = 32'd8;
        req_addr[1*AW +: AW]  = 32'h6000;
        req_beats[1*AW +: AW] = 32'd8;
        req_valid = 4'b0011;
        step();
        check_output("zl_ptr_grant", 64'(grant), 64'h2);
        check_output("zl_ptr_aaddr", 64'(ad_aaddr), 64'h6000);

        $display("[TB] asynchronous reset mid-transfer");
        #2;
        resetn = 1'b0;
        #1;
        check_output("arst_grant", 64'(grant), 64'h0);
        check_output("arst_avalid", 64'(ad_avalid), 64'h0);
        check_output("arst_busy", 64'(busy), 64'h0);
        check_output("arst_req_ready", 64'(req_ready), 64'h0);
        check_output("arst_aaddr", 64'(ad_aaddr), 64'h0);
        req_valid = 4'b0101;
        req_beats[2*AW +: AW] = 32'd3;
        #1;
        resetn = 1'b1;
        step();
        check_output("arst_regrant", 64'(grant), 64'h1);
        check_output("arst_regrant_avalid", 64'(ad_avalid), 64'h1);
        check_output("arst_no_req_ready", 64'(req_ready), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
